// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-shot access sequencer for the shared 32x8 data memory.
// Build option: define ARB_FIXED_PRIO_EN for fixed port-0 priority (default is round-robin).
module dmem_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_w_r0,
   input  logic                  i_w_r1,
   input  logic [ADDR_BITS-1:0]  i_addr0,
   input  logic [ADDR_BITS-1:0]  i_addr1,
   input  logic [DATA_WIDTH-1:0] i_wdata0,
   input  logic [DATA_WIDTH-1:0] i_wdata1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_ack0,
   output logic                  o_ack1,
   output logic [DATA_WIDTH-1:0] o_rdata0,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   output logic                  o_mem_en,
   output logic                  o_mem_w_r,
   output logic [ADDR_BITS-1:0]  o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b001,
      S_ACCESS = 3'b010,
      S_DONE   = 3'b100
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_owner;
   logic                  r_mem_w_r;
   logic [ADDR_BITS-1:0]  r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic                  w_any;
   logic                  w_pick1;
   logic                  w_busy;
   logic                  w_rd_done;

   assign w_any = i_req0 | i_req1;

`ifdef ARB_FIXED_PRIO_EN
   assign w_pick1 = i_req1 & ~i_req0;
`else
   logic r_last;
   // On a tie the port that did not win last time is served.
   assign w_pick1 = i_req1 & (~i_req0 | ~r_last);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Illegal one-hot codes fall through to IDLE.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = w_any ? S_ACCESS : S_IDLE;
         S_ACCESS: w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner     <= 1'b0;
         r_mem_w_r   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
`ifndef ARB_FIXED_PRIO_EN
         r_last      <= 1'b1;
`endif
      end else begin
         if (r_state == S_IDLE && w_any) begin
            r_owner     <= w_pick1;
            r_mem_w_r   <= w_pick1 ? i_w_r1   : i_w_r0;
            r_mem_addr  <= w_pick1 ? i_addr1  : i_addr0;
            r_mem_wdata <= w_pick1 ? i_wdata1 : i_wdata0;
`ifndef ARB_FIXED_PRIO_EN
            r_last      <= w_pick1;
`endif
         end
         if (w_rd_done) begin
            if (r_owner) r_rdata1 <= i_mem_rdata;
            else         r_rdata0 <= i_mem_rdata;
         end
      end
   end

   assign w_busy    = (r_state == S_ACCESS) || (r_state == S_DONE);
   assign w_rd_done = (r_state == S_DONE) && !r_mem_w_r;

   // Read data is forwarded during the ack cycle and held in r_rdata* afterwards.
   always_comb begin
      o_mem_en = 1'b0;
      o_gnt0   = 1'b0;
      o_gnt1   = 1'b0;
      o_ack0   = 1'b0;
      o_ack1   = 1'b0;
      o_rdata0 = r_rdata0;
      o_rdata1 = r_rdata1;
      o_mem_en = (r_state == S_ACCESS);
      o_gnt0   = w_busy & ~r_owner;
      o_gnt1   = w_busy &  r_owner;
      o_ack0   = (r_state == S_DONE) & ~r_owner;
      o_ack1   = (r_state == S_DONE) &  r_owner;
      if (w_rd_done && !r_owner) o_rdata0 = i_mem_rdata;
      if (w_rd_done &&  r_owner) o_rdata1 = i_mem_rdata;
   end

   assign o_mem_w_r   = r_mem_w_r;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous 32x8 memory.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, w_r0 = 1'b0, w_r1 = 1'b0;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, ack0, ack1, mem_en, mem_w_r;
   logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [4:0] mem_addr;
   logic [7:0] mem [32];

   int n_pass  = 0;
   int n_total = 0;

   dmem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .clk(clk), .rst(rst),
      .i_req0(req0), .i_req1(req1), .i_w_r0(w_r0), .i_w_r1(w_r1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
      .o_rdata0(rdata0), .o_rdata1(rdata1),
      .o_mem_en(mem_en), .o_mem_w_r(mem_w_r), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Read-first synchronous memory.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_w_r) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         n_total++;
         assert (!(gnt0 && gnt1) && !(ack0 && !gnt0) && !(ack1 && !gnt1)) n_pass++;
         else $error("FAIL gnt_ack_excl observed=%b%b%b%b expected=no overlap", gnt0, gnt1, ack0, ack1);
      end
   end

   task automatic request(input int p, input logic wr, input logic [4:0] a, input logic [7:0] d);
      if (p == 0) begin w_r0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1; end
      else        begin w_r1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1; end
   endtask

   // One access granted at the next edge: ACCESS, DONE, back to IDLE.
   task automatic serve(input int p, input logic wr, input logic [4:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input bit drop);
      logic [1:0] g;
      g = (p == 0) ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      chk("access_gnt",   32'({gnt1, gnt0}), 32'(g));
      chk("access_mem_en", 32'(mem_en), 32'd1);
      chk("access_w_r",   32'(mem_w_r), 32'(wr));
      chk("access_addr",  32'(mem_addr), 32'(a));
      if (wr) chk("access_wdata", 32'(mem_wdata), 32'(d));
      chk("access_no_ack", 32'({ack1, ack0}), 32'd0);
      @(posedge clk); #1;
      chk("done_mem_en", 32'(mem_en), 32'd0);
      chk("done_ack",    32'({ack1, ack0}), 32'(g));
      chk("done_gnt",    32'({gnt1, gnt0}), 32'(g));
      chk("done_rdata",  32'((p == 0) ? rdata0 : rdata1), 32'(exp_rd));
      if (drop) begin
         if (p == 0) req0 = 1'b0;
         else        req1 = 1'b0;
      end
      @(posedge clk); #1;
      chk("idle_ack", 32'({ack1, ack0}), 32'd0);
      chk("idle_gnt", 32'({gnt1, gnt0}), 32'd0);
      chk("idle_rdata", 32'((p == 0) ? rdata0 : rdata1), 32'(exp_rd));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"},   32'({gnt1, gnt0}), 32'd0);
      chk({tag, "_ack"},   32'({ack1, ack0}), 32'd0);
      chk({tag, "_rdata"}, 32'({rdata1, rdata0}), 32'd0);
      chk({tag, "_mem"},   32'({mem_en, mem_w_r, mem_addr, mem_wdata}), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[1] <= 8'h11;
      mem[2] <= 8'h22;
      #1 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Port 0 write then read back.
      request(0, 1'b1, 5'd5, 8'hA5);
      serve(0, 1'b1, 5'd5, 8'hA5, 8'h00, 1'b1);
      request(0, 1'b0, 5'd5, 8'h00);
      serve(0, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1);

      // Port 1 write to top address; rdata1 unchanged.
      request(1, 1'b1, 5'd31, 8'h3C);
      serve(1, 1'b1, 5'd31, 8'h3C, 8'h00, 1'b1);
      chk("mem31", 32'(mem[31]), 32'h3C);

      // Request held through ack gives a second access.
      request(0, 1'b0, 5'd5, 8'h00);
      serve(0, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b0);
      serve(0, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1);

      // Reset, then simultaneous reads: port 0 first.
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset2");
      #1 rst = 1'b0;
      request(0, 1'b0, 5'd1, 8'h00);
      request(1, 1'b0, 5'd2, 8'h00);
      serve(0, 1'b0, 5'd1, 8'h00, 8'h11, 1'b1);
      serve(1, 1'b0, 5'd2, 8'h00, 8'h22, 1'b1);

      // Both ports requesting continuously for 12 cycles.
      request(0, 1'b0, 5'd1, 8'h00);
      request(1, 1'b0, 5'd2, 8'h00);
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
         serve(0, 1'b0, 5'd1, 8'h00, 8'h11, 1'b0);
`else
         if ((i % 2) == 0) serve(0, 1'b0, 5'd1, 8'h00, 8'h11, 1'b0);
         else              serve(1, 1'b0, 5'd2, 8'h00, 8'h22, 1'b0);
`endif
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
      chk("quiet_gnt", 32'({gnt1, gnt0}), 32'd0);

      // Reset during the ACCESS cycle of a port 0 write.
      request(0, 1'b1, 5'd7, 8'h77);
      @(posedge clk); #1;
      chk("abort_pre_en",  32'(mem_en), 32'd1);
      chk("abort_pre_gnt", 32'({gnt1, gnt0}), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("abort");
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("abort_hold_ack", 32'({ack1, ack0}), 32'd0);
      chk("abort_hold_en",  32'(mem_en), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_post_ack", 32'({ack1, ack0}), 32'd0);
      chk("abort_post_gnt", 32'({gnt1, gnt0}), 32'd0);
      request(0, 1'b0, 5'd1, 8'h00);
      request(1, 1'b0, 5'd2, 8'h00);
      serve(0, 1'b0, 5'd1, 8'h00, 8'h11, 1'b1);
      serve(1, 1'b0, 5'd2, 8'h00, 8'h22, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
